int_div_unit: RTL and testbench



---
 rtl/int_div_unit.sv | 179 +++++++++++++++++
 tb/tb_int_div_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/int_div_unit.sv
// Iterative restoring integer divider for RISC-V DIV/DIVU/REM/REMU.
// Retires BPC quotient bits per cycle; zero divisor, signed overflow and repeated operands complete in one cycle.
module int_div_unit #(
    parameter int XLEN      = 32,
    parameter int BPC       = 4,
    parameter int CACHE_ENA = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            load,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            busy,
    output logic            ready
);
    localparam int ITER = XLEN / BPC;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r, y_r;
    logic [XLEN-1:0] a_r, b_r;
    logic [1:0]      op_r;
    logic            neg_q_r, neg_r_r;
    logic            c_vld_r, c_op0_r;
    logic [XLEN-1:0] c_a_r, c_b_r, c_q_r, c_r_r;

    logic            sgn_s, div0_s, ovf_s, hit_s, fast_s, start_s, cache_on_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, fast_q_s, fast_r_s;
    logic [XLEN-1:0] step_rem_s, step_quo_s, fix_q_s, fix_r_s;

    assign cache_on_s = (CACHE_ENA != 0);
    assign sgn_s      = ~op[0];
    assign div0_s     = (b == {XLEN{1'b0}});
    assign ovf_s      = sgn_s && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
    assign hit_s      = cache_on_s && c_vld_r && (a == c_a_r) && (b == c_b_r) && (op[0] == c_op0_r);
    assign fast_s     = div0_s || ovf_s || hit_s;
    assign start_s    = load && !flush && ((state_r == IDLE) || (state_r == DONE));
    assign a_mag_s    = (sgn_s && a[XLEN-1]) ? ({XLEN{1'b0}} - a) : a;
    assign b_mag_s    = (sgn_s && b[XLEN-1]) ? ({XLEN{1'b0}} - b) : b;
    assign fix_q_s    = neg_q_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
    assign fix_r_s    = neg_r_r ? ({XLEN{1'b0}} - rem_r) : rem_r;

    // Single-cycle results for the special operand cases
    always_comb begin
        fast_q_s = c_q_r;
        fast_r_s = c_r_r;
        if (div0_s) begin
            fast_q_s = {XLEN{1'b1}};
            fast_r_s = a;
        end else if (ovf_s) begin
            fast_q_s = a;
            fast_r_s = {XLEN{1'b0}};
        end else begin
            fast_q_s = c_q_r;
            fast_r_s = c_r_r;
        end
    end

    // BPC unrolled restoring steps; quo_r shifts the dividend out as quotient bits enter
    always_comb begin
        logic [XLEN:0]   r_v;
        logic [XLEN-1:0] q_v;
        r_v = {1'b0, rem_r};
        q_v = quo_r;
        for (int i = 0; i < BPC; i++) begin
            r_v = {r_v[XLEN-1:0], q_v[XLEN-1]};
            q_v = {q_v[XLEN-2:0], 1'b0};
            if (r_v >= {1'b0, dvs_r}) begin
                r_v    = r_v - {1'b0, dvs_r};
                q_v[0] = 1'b1;
            end else begin
                r_v = r_v;
            end
        end
        step_rem_s = r_v[XLEN-1:0];
        step_quo_s = q_v;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Next-state logic; flush overrides everything, including a simultaneous load
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = load ? (fast_s ? DONE : CALC) : IDLE;
                CALC:    state_nxt_s = (cnt_r == {CW{1'b0}}) ? FIX : CALC;
                FIX:     state_nxt_s = DONE;
                DONE:    state_nxt_s = load ? (fast_s ? DONE : CALC) : IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy  = 1'b0;
        ready = 1'b0;
        case (state_r)
            CALC:    busy  = 1'b1;
            FIX:     busy  = 1'b1;
            DONE:    ready = !flush;
            default: begin
                busy  = 1'b0;
                ready = 1'b0;
            end
        endcase
    end

    // Datapath, result and cache registers; the cache is written on the edge entering DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {CW{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            quo_r   <= {XLEN{1'b0}};
            dvs_r   <= {XLEN{1'b0}};
            y_r     <= {XLEN{1'b0}};
            a_r     <= {XLEN{1'b0}};
            b_r     <= {XLEN{1'b0}};
            op_r    <= 2'b00;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            c_vld_r <= 1'b0;
            c_op0_r <= 1'b0;
            c_a_r   <= {XLEN{1'b0}};
            c_b_r   <= {XLEN{1'b0}};
            c_q_r   <= {XLEN{1'b0}};
            c_r_r   <= {XLEN{1'b0}};
        end else if (start_s && fast_s) begin
            y_r <= op[1] ? fast_r_s : fast_q_s;
            if (cache_on_s) begin
                c_vld_r <= 1'b1;
                c_op0_r <= op[0];
                c_a_r   <= a;
                c_b_r   <= b;
                c_q_r   <= fast_q_s;
                c_r_r   <= fast_r_s;
            end
        end else if (start_s) begin
            quo_r   <= a_mag_s;
            dvs_r   <= b_mag_s;
            rem_r   <= {XLEN{1'b0}};
            cnt_r   <= CW'(ITER - 1);
            neg_q_r <= sgn_s & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_r <= sgn_s & a[XLEN-1];
            op_r    <= op;
            a_r     <= a;
            b_r     <= b;
        end else if ((state_r == CALC) && !flush) begin
            rem_r <= step_rem_s;
            quo_r <= step_quo_s;
            cnt_r <= cnt_r - CW'(1);
        end else if ((state_r == FIX) && !flush) begin
            y_r <= op_r[1] ? fix_r_s : fix_q_s;
            if (cache_on_s) begin
                c_vld_r <= 1'b1;
                c_op0_r <= op_r[0];
                c_a_r   <= a_r;
                c_b_r   <= b_r;
                c_q_r   <= fix_q_s;
                c_r_r   <= fix_r_s;
            end
        end
    end

    assign y = y_r;
endmodule

// File: tb/tb_int_div_unit.sv
// Directed bench for int_div_unit: latency, results, fast paths, cache, flush and reset.
module tb_int_div_unit;
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic        clk, reset_n, flush;
    logic [2:0]  load_v;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [31:0] y0, y1, y8;
    logic        busy0, busy1, busy8, ready0, ready1, ready8;
    int          n_checks, n_fail;
    logic [31:0] last_y;

    int_div_unit #(.XLEN(32), .BPC(4), .CACHE_ENA(1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .load(load_v[0]), .op(op_i),
        .a(a_i), .b(b_i), .y(y0), .busy(busy0), .ready(ready0));
    int_div_unit #(.XLEN(32), .BPC(1), .CACHE_ENA(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .load(load_v[1]), .op(op_i),
        .a(a_i), .b(b_i), .y(y1), .busy(busy1), .ready(ready1));
    int_div_unit #(.XLEN(32), .BPC(8), .CACHE_ENA(0)) dut8 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .load(load_v[2]), .op(op_i),
        .a(a_i), .b(b_i), .y(y8), .busy(busy8), .ready(ready8));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(input int s);
        case (s)
            1:       return busy1;
            2:       return busy8;
            default: return busy0;
        endcase
    endfunction

    function automatic logic ready_of(input int s);
        case (s)
            1:       return ready1;
            2:       return ready8;
            default: return ready0;
        endcase
    endfunction

    function automatic logic [31:0] y_of(input int s);
        case (s)
            1:       return y1;
            2:       return y8;
            default: return y0;
        endcase
    endfunction

    // Issue one operation and check ready cycle, busy-cycle count and result.
    // b2b=1: called at the negedge of a ready cycle, so load lands back-to-back.
    task automatic do_op(input string tag, input int sel, input bit b2b, input logic [1:0] o,
                         input logic [31:0] av, input logic [31:0] bv,
                         input int exp_cyc, input logic [31:0] exp_y);
        int          rc, bc;
        logic [31:0] yv;
        if (!b2b) begin
            @(negedge clk);
            check_eq({tag, "_idle_ready"}, {31'd0, ready_of(sel)}, 32'd0);
            if (sel == 0) check_eq({tag, "_y_hold"}, y0, last_y);
        end
        op_i = o; a_i = av; b_i = bv;
        load_v[sel] = 1'b1;
        @(posedge clk);
        #1 load_v = 3'b000;
        rc = -1; bc = 0; yv = 32'd0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (ready_of(sel)) begin
                rc = c;
                yv = y_of(sel);
                check_eq({tag, "_busy_at_ready"}, {31'd0, busy_of(sel)}, 32'd0);
                break;
            end
            if (busy_of(sel)) bc++;
        end
        check_eq({tag, "_ready_cycle"}, rc, exp_cyc);
        check_eq({tag, "_busy_cycles"}, bc, exp_cyc - 1);
        check_eq({tag, "_y"}, yv, exp_y);
        if (sel == 0) last_y = exp_y;
    endtask

    initial begin
        bit saw;
        n_checks = 0; n_fail = 0; last_y = 32'd0;
        clk = 1'b0; reset_n = 1'b0; flush = 1'b0; load_v = 3'b000;
        op_i = 2'b00; a_i = 32'd0; b_i = 32'd0;
        #12;
        check_eq("rst_y", y0, 32'd0);
        check_eq("rst_busy", {31'd0, busy0}, 32'd0);
        check_eq("rst_ready", {31'd0, ready0}, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        do_op("divu_100_7", 0, 1'b0, DIVU, 32'd100, 32'd7, 10, 32'd14);
        do_op("remu_hit", 0, 1'b1, REMU, 32'd100, 32'd7, 1, 32'd2);
        do_op("div_100_7", 0, 1'b0, DIV, 32'd100, 32'd7, 10, 32'd14);
        do_op("div_m7_2", 0, 1'b0, DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFD);
        do_op("rem_m7_2", 0, 1'b0, REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF);
        do_op("rem_7_m2", 0, 1'b0, REM, 32'd7, 32'hFFFF_FFFE, 10, 32'd1);
        do_op("remu_b2b", 0, 1'b1, REMU, 32'd12345, 32'd100, 10, 32'd45);
        do_op("divu_max", 0, 1'b0, DIVU, 32'hFFFF_FFFF, 32'd16, 10, 32'h0FFF_FFFF);
        do_op("remu_max", 0, 1'b1, REMU, 32'hFFFF_FFFF, 32'd16, 1, 32'h0000_000F);
        do_op("divu_5_0", 0, 1'b0, DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        do_op("rem_5_0", 0, 1'b0, REM, 32'd5, 32'd0, 1, 32'd5);
        do_op("div_ovf", 0, 1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        do_op("rem_ovf", 0, 1'b0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        // Flush in cycle 4 of DIVU 1000/3
        @(negedge clk);
        op_i = DIVU; a_i = 32'd1000; b_i = 32'd3; load_v[0] = 1'b1;
        @(posedge clk);
        #1 load_v = 3'b000;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check_eq("flush_busy_before", {31'd0, busy0}, 32'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_eq("flush_busy_after", {31'd0, busy0}, 32'd0);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ready0) saw = 1'b1;
        end
        check_eq("flush_no_ready", {31'd0, saw}, 32'd0);
        check_eq("flush_y_kept", y0, 32'd0);
        do_op("divu_reissue", 0, 1'b0, DIVU, 32'd1000, 32'd3, 10, 32'd333);

        // Asynchronous reset in the middle of cycle 5
        @(negedge clk);
        op_i = DIVU; a_i = 32'd50000; b_i = 32'd9; load_v[0] = 1'b1;
        @(posedge clk);
        #1 load_v = 3'b000;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_y", y0, 32'd0);
        check_eq("async_rst_busy", {31'd0, busy0}, 32'd0);
        check_eq("async_rst_ready", {31'd0, ready0}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        last_y = 32'd0;
        do_op("remu_after_rst", 0, 1'b0, REMU, 32'd100, 32'd7, 10, 32'd2);

        do_op("bpc1_divu", 1, 1'b0, DIVU, 32'd100, 32'd7, 34, 32'd14);
        do_op("bpc8_divu", 2, 1'b0, DIVU, 32'd100, 32'd7, 6, 32'd14);
        do_op("bpc8_nocache", 2, 1'b0, DIVU, 32'd100, 32'd7, 6, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
